free_list_enq_buffer: RTL and testbench

- Write side of the banked physical-register free list.
- Accepts up to COMMIT_WIDTH freed physical registers (PRs) per cycle from ROB commit/retire.
- Steers each PR to its bank FIFO by the low PR bits, then drains at most one PR per bank per cycle into the free_list banks over a valid/ready handshake.
- Decouples multi-lane commit bursts from single-port-per-bank free_list enqueue.

---
 rtl/free_list_enq_buffer.sv | 147 ++++++++++++++
 tb/tb_free_list_enq_buffer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/free_list_enq_buffer.sv
// Write side of the banked physical-register free list: steers freed PRs from
// the commit lanes into per-bank FIFOs and drains one PR per bank per cycle.

module free_list_enq_bank #(
    parameter int LOG_PR_COUNT             = 7,
    parameter int LOG_FREE_LIST_BANK_COUNT = 2,
    parameter int COMMIT_WIDTH             = 4,
    parameter int ENQ_BUFFER_DEPTH         = 8,
    parameter int CNT_W                    = 4,
    parameter int BANK_ID                  = 0
) (
    input  logic                                      CLK,
    input  logic                                      RST,
    input  logic                                      push_en,
    input  logic [COMMIT_WIDTH-1:0]                   commit_valid_by_lane,
    input  logic [COMMIT_WIDTH-1:0][LOG_PR_COUNT-1:0] commit_pr_by_lane,
    output logic                                      enq_valid,
    output logic [LOG_PR_COUNT-1:0]                   enq_pr,
    input  logic                                      enq_ready,
    output logic [CNT_W-1:0]                          count
);
    localparam int PTR_W = CNT_W - 1;
    localparam logic [PTR_W+1:0] DEPTH_W = (PTR_W+2)'(ENQ_BUFFER_DEPTH);
    localparam logic [LOG_FREE_LIST_BANK_COUNT-1:0] BANK_SEL =
        LOG_FREE_LIST_BANK_COUNT'(BANK_ID);

    logic [LOG_PR_COUNT-1:0]            entries [ENQ_BUFFER_DEPTH];
    logic [PTR_W-1:0]                   rd_ptr;
    logic [PTR_W-1:0]                   wr_ptr;
    logic [COMMIT_WIDTH-1:0]            hit;
    logic [COMMIT_WIDTH-1:0][PTR_W-1:0] slot;
    logic [CNT_W-1:0]                   num_push;
    logic                               pop;
    logic                               no_overflow;

    // Pointer add modulo the FIFO depth; inc never exceeds the depth, so one
    // conditional subtract is enough even for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] ptr,
                                                  input logic [CNT_W-1:0] inc);
        logic [PTR_W+1:0] sum;
        sum = {2'b00, ptr} + {1'b0, inc};
        if (sum >= DEPTH_W)
            sum = sum - DEPTH_W;
        return sum[PTR_W-1:0];
    endfunction

    // Lanes that target this bank take consecutive slots in ascending lane order.
    always_comb begin
        num_push = '0;
        hit      = '0;
        slot     = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            hit[i]  = push_en && commit_valid_by_lane[i] &&
                      (commit_pr_by_lane[i][LOG_FREE_LIST_BANK_COUNT-1:0] == BANK_SEL);
            slot[i] = wrap_add(wr_ptr, num_push);
            if (hit[i])
                num_push = num_push + CNT_W'(1);
        end
    end

    assign enq_valid = (count != '0);
    assign enq_pr    = entries[rd_ptr];
    assign pop       = enq_valid && enq_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop)
                rd_ptr <= wrap_add(rd_ptr, CNT_W'(1));
            wr_ptr <= wrap_add(wr_ptr, num_push);
            count  <= count + num_push - CNT_W'(pop);
        end
    end

    // Storage is deliberately not reset; pointers alone define what is live.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (hit[i])
                    entries[slot[i]] <= commit_pr_by_lane[i];
            end
        end
    end

    assign no_overflow = ((CNT_W+1)'(count) + (CNT_W+1)'(num_push)) <=
                         ((CNT_W+1)'(ENQ_BUFFER_DEPTH) + (CNT_W+1)'(pop));

    a_no_overflow: assert property (@(posedge CLK) disable iff (RST) no_overflow);

endmodule

module free_list_enq_buffer #(
    parameter int PR_COUNT                 = 128,
    parameter int LOG_PR_COUNT             = $clog2(PR_COUNT),
    parameter int FREE_LIST_BANK_COUNT     = 4,
    parameter int LOG_FREE_LIST_BANK_COUNT = $clog2(FREE_LIST_BANK_COUNT),
    parameter int COMMIT_WIDTH             = 4,
    parameter int ENQ_BUFFER_DEPTH         = 8
) (
    input  logic                                                        CLK,
    input  logic                                                        RST,
    input  logic [COMMIT_WIDTH-1:0]                                     commit_valid_by_lane,
    input  logic [COMMIT_WIDTH-1:0][LOG_PR_COUNT-1:0]                   commit_pr_by_lane,
    output logic                                                        commit_ready,
    output logic [FREE_LIST_BANK_COUNT-1:0]                             enq_valid_by_bank,
    output logic [FREE_LIST_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]           enq_pr_by_bank,
    input  logic [FREE_LIST_BANK_COUNT-1:0]                             enq_ready_by_bank,
    output logic [FREE_LIST_BANK_COUNT-1:0][$clog2(ENQ_BUFFER_DEPTH):0] bank_occupancy_by_bank
);
    localparam int CNT_W = $clog2(ENQ_BUFFER_DEPTH) + 1;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(ENQ_BUFFER_DEPTH - COMMIT_WIDTH);

    // Reserve room for a whole burst landing in one bank; built only from
    // registered counts so no input reaches commit_ready combinationally.
    always_comb begin
        commit_ready = 1'b1;
        for (int b = 0; b < FREE_LIST_BANK_COUNT; b++) begin
            if (bank_occupancy_by_bank[b] > READY_MAX)
                commit_ready = 1'b0;
        end
    end

    for (genvar b = 0; b < FREE_LIST_BANK_COUNT; b++) begin : gen_bank
        free_list_enq_bank #(
            .LOG_PR_COUNT            (LOG_PR_COUNT),
            .LOG_FREE_LIST_BANK_COUNT(LOG_FREE_LIST_BANK_COUNT),
            .COMMIT_WIDTH            (COMMIT_WIDTH),
            .ENQ_BUFFER_DEPTH        (ENQ_BUFFER_DEPTH),
            .CNT_W                   (CNT_W),
            .BANK_ID                 (b)
        ) u_bank (
            .CLK                 (CLK),
            .RST                 (RST),
            .push_en             (commit_ready),
            .commit_valid_by_lane(commit_valid_by_lane),
            .commit_pr_by_lane   (commit_pr_by_lane),
            .enq_valid           (enq_valid_by_bank[b]),
            .enq_pr              (enq_pr_by_bank[b]),
            .enq_ready           (enq_ready_by_bank[b]),
            .count               (bank_occupancy_by_bank[b])
        );
    end

endmodule

// File: tb/tb_free_list_enq_buffer.sv
// Directed table-driven bench for free_list_enq_buffer plus a wrap-around
// sequence checked against a queue model.

module tb_free_list_enq_buffer;
    logic                 CLK = 1'b0;
    logic                 RST;
    logic [3:0]           commit_valid_by_lane;
    logic [3:0][6:0]      commit_pr_by_lane;
    logic                 commit_ready;
    logic [3:0]           enq_valid_by_bank;
    logic [3:0][6:0]      enq_pr_by_bank;
    logic [3:0]           enq_ready_by_bank;
    logic [3:0][3:0]      bank_occupancy_by_bank;

    int n_chk  = 0;
    int n_fail = 0;

    free_list_enq_buffer dut (
        .CLK                   (CLK),
        .RST                   (RST),
        .commit_valid_by_lane  (commit_valid_by_lane),
        .commit_pr_by_lane     (commit_pr_by_lane),
        .commit_ready          (commit_ready),
        .enq_valid_by_bank     (enq_valid_by_bank),
        .enq_pr_by_bank        (enq_pr_by_bank),
        .enq_ready_by_bank     (enq_ready_by_bank),
        .bank_occupancy_by_bank(bank_occupancy_by_bank)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic            rst;
        logic [3:0]      cv;
        logic [3:0][6:0] cp;
        logic [3:0]      er;
        logic            xr;
        logic [3:0]      xv;
        logic [3:0][6:0] xp;
        logic [3:0][3:0] xo;
    } vec_t;

    vec_t t[$];

    function automatic vec_t v(input bit rst, input bit [3:0] cv,
                               input int p0, input int p1, input int p2, input int p3,
                               input bit [3:0] er, input bit xr, input bit [3:0] xv,
                               input int h0, input int h1, input int h2, input int h3,
                               input int o0, input int o1, input int o2, input int o3);
        vec_t r;
        r.rst = rst; r.cv = cv; r.er = er; r.xr = xr; r.xv = xv;
        r.cp[0] = 7'(p0); r.cp[1] = 7'(p1); r.cp[2] = 7'(p2); r.cp[3] = 7'(p3);
        r.xp[0] = 7'(h0); r.xp[1] = 7'(h1); r.xp[2] = 7'(h2); r.xp[3] = 7'(h3);
        r.xo[0] = 4'(o0); r.xo[1] = 4'(o1); r.xo[2] = 4'(o2); r.xo[3] = 4'(o3);
        return r;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        // reset / idle
        t.push_back(v(0,4'b0000, 0, 0, 0, 0,4'b1111, 1,4'b0000,  0, 0, 0, 0, 0,0,0,0));
        // one PR per bank, drained the next cycle
        t.push_back(v(0,4'b1111, 4, 9,14,19,4'b1111, 1,4'b0000,  0, 0, 0, 0, 0,0,0,0));
        t.push_back(v(0,4'b0000, 0, 0, 0, 0,4'b1111, 1,4'b1111,  4, 9,14,19, 1,1,1,1));
        t.push_back(v(0,4'b0000, 0, 0, 0, 0,4'b0000, 1,4'b0000,  0, 0, 0, 0, 0,0,0,0));
        // two full bursts into bank 0, third burst blocked by commit_ready=0
        t.push_back(v(0,4'b1111, 8,12,16,20,4'b0000, 1,4'b0000,  0, 0, 0, 0, 0,0,0,0));
        t.push_back(v(0,4'b1111, 8,12,16,20,4'b0000, 1,4'b0001,  8, 0, 0, 0, 4,0,0,0));
        t.push_back(v(0,4'b1111,24,28,32,36,4'b0000, 0,4'b0001,  8, 0, 0, 0, 8,0,0,0));
        t.push_back(v(0,4'b0000, 0, 0, 0, 0,4'b0001, 0,4'b0001,  8, 0, 0, 0, 8,0,0,0));
        t.push_back(v(0,4'b0000, 0, 0, 0, 0,4'b0001, 0,4'b0001, 12, 0, 0, 0, 7,0,0,0));
        t.push_back(v(0,4'b0000, 0, 0, 0, 0,4'b0001, 0,4'b0001, 16, 0, 0, 0, 6,0,0,0));
        t.push_back(v(0,4'b0000, 0, 0, 0, 0,4'b0001, 0,4'b0001, 20, 0, 0, 0, 5,0,0,0));
        t.push_back(v(0,4'b0000, 0, 0, 0, 0,4'b0001, 1,4'b0001,  8, 0, 0, 0, 4,0,0,0));
        t.push_back(v(0,4'b0000, 0, 0, 0, 0,4'b0001, 1,4'b0001, 12, 0, 0, 0, 3,0,0,0));
        t.push_back(v(0,4'b0000, 0, 0, 0, 0,4'b0001, 1,4'b0001, 16, 0, 0, 0, 2,0,0,0));
        t.push_back(v(0,4'b0000, 0, 0, 0, 0,4'b0001, 1,4'b0001, 20, 0, 0, 0, 1,0,0,0));
        t.push_back(v(0,4'b0000, 0, 0, 0, 0,4'b0000, 1,4'b0000,  0, 0, 0, 0, 0,0,0,0));
        // bank 1: push 2 (gapped lanes) while popping
        t.push_back(v(0,4'b0111, 1,17,33, 0,4'b0000, 1,4'b0000,  0, 0, 0, 0, 0,0,0,0));
        t.push_back(v(0,4'b1010, 6, 5, 6,13,4'b0010, 1,4'b0010,  0, 1, 0, 0, 0,3,0,0));
        t.push_back(v(0,4'b0000, 0, 0, 0, 0,4'b0010, 1,4'b0010,  0,17, 0, 0, 0,4,0,0));
        t.push_back(v(0,4'b0000, 0, 0, 0, 0,4'b0010, 1,4'b0010,  0,33, 0, 0, 0,3,0,0));
        t.push_back(v(0,4'b0000, 0, 0, 0, 0,4'b0010, 1,4'b0010,  0, 5, 0, 0, 0,2,0,0));
        t.push_back(v(0,4'b0000, 0, 0, 0, 0,4'b0010, 1,4'b0010,  0,13, 0, 0, 0,1,0,0));
        t.push_back(v(0,4'b0000, 0, 0, 0, 0,4'b0000, 1,4'b0000,  0, 0, 0, 0, 0,0,0,0));
        // bank 3 at 5 entries, then reset mid-burst
        t.push_back(v(0,4'b1111, 3, 7,11,15,4'b0000, 1,4'b0000,  0, 0, 0, 0, 0,0,0,0));
        t.push_back(v(0,4'b0001,19, 0, 0, 0,4'b0000, 1,4'b1000,  0, 0, 0, 3, 0,0,0,4));
        t.push_back(v(1,4'b1111,23,27,31,35,4'b0000, 0,4'b1000,  0, 0, 0, 3, 0,0,0,5));
        t.push_back(v(0,4'b0000, 0, 0, 0, 0,4'b0000, 1,4'b0000,  0, 0, 0, 0, 0,0,0,0));
        // reset while commit_ready=1 and lanes valid: nothing buffered
        t.push_back(v(1,4'b1111, 3, 7,11,15,4'b0000, 1,4'b0000,  0, 0, 0, 0, 0,0,0,0));
        t.push_back(v(0,4'b0000, 0, 0, 0, 0,4'b0000, 1,4'b0000,  0, 0, 0, 0, 0,0,0,0));

        RST = 1'b1;
        commit_valid_by_lane = '0;
        commit_pr_by_lane    = '0;
        enq_ready_by_bank    = '0;
        repeat (2) @(posedge CLK);
        #1;

        for (int k = 0; k < t.size(); k++) begin
            RST                  = t[k].rst;
            commit_valid_by_lane = t[k].cv;
            commit_pr_by_lane    = t[k].cp;
            enq_ready_by_bank    = t[k].er;
            @(negedge CLK);
            check($sformatf("v%0d commit_ready", k), int'(commit_ready), int'(t[k].xr));
            check($sformatf("v%0d enq_valid", k), int'(enq_valid_by_bank), int'(t[k].xv));
            for (int b = 0; b < 4; b++) begin
                check($sformatf("v%0d occ[%0d]", k, b), int'(bank_occupancy_by_bank[b]),
                      int'(t[k].xo[b]));
                if (t[k].xv[b])
                    check($sformatf("v%0d head[%0d]", k, b), int'(enq_pr_by_bank[b]),
                          int'(t[k].xp[b]));
            end
            @(posedge CLK);
            #1;
        end

        // Wrap-around: 20 single PRs through bank 2, enq_ready toggling.
        begin
            int q[$];
            int next_idx = 0;
            int popped   = 0;
            int cyc      = 0;
            bit er2, m_ready, do_push;
            RST = 1'b0;
            while ((next_idx < 20 || q.size() > 0) && cyc < 300) begin
                er2 = (cyc % 2) == 1;
                commit_valid_by_lane = (next_idx < 20) ? 4'b0001 : 4'b0000;
                commit_pr_by_lane    = '0;
                commit_pr_by_lane[0] = 7'(2 + 4 * next_idx);
                enq_ready_by_bank    = {1'b0, er2, 2'b00};
                @(negedge CLK);
                m_ready = q.size() <= 4;
                check($sformatf("wrap c%0d commit_ready", cyc), int'(commit_ready), int'(m_ready));
                check($sformatf("wrap c%0d occ2", cyc), int'(bank_occupancy_by_bank[2]), q.size());
                check($sformatf("wrap c%0d valid2", cyc), int'(enq_valid_by_bank[2]),
                      int'(q.size() != 0));
                if (bank_occupancy_by_bank[2] > 4'd8)
                    check($sformatf("wrap c%0d occ2 bound", cyc),
                          int'(bank_occupancy_by_bank[2]), 8);
                if (q.size() != 0)
                    check($sformatf("wrap c%0d head2", cyc), int'(enq_pr_by_bank[2]), q[0]);
                do_push = (next_idx < 20) && m_ready;
                if (er2 && q.size() > 0) begin
                    void'(q.pop_front());
                    popped++;
                end
                if (do_push) begin
                    q.push_back(2 + 4 * next_idx);
                    next_idx++;
                end
                @(posedge CLK);
                #1;
                cyc++;
            end
            check("wrap drained count", popped, 20);
            commit_valid_by_lane = '0;
            enq_ready_by_bank    = '0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
